alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Operand staging buffer directly upstream of the Mini ALU datapath (6-bit comparator, adders, logic units).
//  Accepts {opcode, A, B} transactions over a valid/ready handshake and holds them in a small FIFO.
//  Presents the head entry as registered operands: m_in1/m_in2 drive the comparator's in1/in2.
//  Decouples the operand source from ALU back-pressure; counts accepted and issued operations.
// PARAMETERS
//  WIDTH  6  operand width in bits; matches the comparator inputs
//  OPW    3  opcode width in bits
//  DEPTH  4  FIFO entries; power of 2, >= 2
//  CNTW   8  width of the accepted/issued counters
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  flush      in   1      synchronous discard of all buffered entries
//  s_valid    in   1      upstream transaction valid
//  s_ready    out  1      stage can accept a transaction
//  s_op       in   OPW    opcode
//  s_a        in   WIDTH  operand A
//  s_b        in   WIDTH  operand B
//  m_valid    out  1      head entry valid toward the ALU
//  m_ready    in   1      ALU consumes the head entry
//  m_op       out  OPW    head opcode
//  m_in1      out  WIDTH  head operand A (to comparator in1)
//  m_in2      out  WIDTH  head operand B (to comparator in2)
//  level      out  log2(DEPTH)+1  occupancy, 0..DEPTH
//  acc_cnt    out  CNTW   accepted transactions, wraps
//  iss_cnt    out  CNTW   issued transactions, wraps
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high.
//  - Reset values: s_ready=1, m_valid=0, m_op/m_in1/m_in2=0, level=0, acc_cnt=0, iss_cnt=0, pointers=0.
//  - push = s_valid & s_ready. pop = m_valid & m_ready. Payload is sampled only on push.
//  - s_ready = (level != DEPTH). It is a function of state only and never depends on m_ready.
//    When full, a pop does not open s_ready in the same cycle.
//  - Latency: a push into an empty stage gives m_valid=1 with that payload on the next cycle.
//  - m_op/m_in1/m_in2 are registers holding the head entry, and are stable while m_valid & !m_ready.
//  - After a pop, the next entry is presented on the following cycle with no bubble if level>1.
//    m_valid falls when the last entry pops with no simultaneous push.
//  - Push and pop in the same cycle: level is unchanged and both pointers advance.
//    With level==1, the pushed entry becomes the head next cycle.
//  - Pointers wrap modulo DEPTH. Full vs empty is resolved by level, not by pointer equality.
//  - Data outputs hold their last value when m_valid=0; the bench must not check them then.
//  - flush has priority over push and pop in the same cycle:
//    level=0, pointers=0, m_valid=0 next cycle; acc_cnt/iss_cnt do not increment that cycle.
//  - acc_cnt += 1 per push and iss_cnt += 1 per pop. Both wrap 2^CNTW-1 -> 0.
//    Invariant: acc_cnt - iss_cnt - level = flushed entries (mod 2^CNTW).
//  - rst asserted mid-operation drops all entries and counters next cycle; same as reset values.
// STRUCTURE
//  - Shared package alu_pkg:
//    - ALU_WIDTH=6, ALU_OPW=3.
//    - Opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_CMP=5.
//    - Typedef alu_req_t {op, a, b}.
//  - One sub-module, alu_op_fifo_mem: DEPTH x (OPW+2*WIDTH) storage array.
//    Write port at wr_ptr; registered read of the head entry.
//  - Top level holds pointers, level, counters and handshake logic.
// TESTING
//  1. Reset, then push {OP_CMP,A=6'h15,B=6'h2A} with m_ready=0:
//     next cycle m_valid=1, m_in1=15, m_in2=2A, level=1, acc_cnt=1.
//  2. Push 4 entries with m_ready=0:
//     level=4, s_ready=0; a 5th s_valid is ignored; acc_cnt=4; head=first entry.
//  3. Full, then m_ready=1 and s_valid=1 for one cycle:
//     pop only (no push); level=3, iss_cnt=1; s_ready=1 next cycle.
//  4. Level=1 with simultaneous push and pop:
//     level stays 1; new entry presented next cycle; m_valid stays 1.
//  5. Level=3, assert flush together with s_valid and m_ready:
//     level=0, m_valid=0, counters unchanged.
//  6. Push/pop 256 times with CNTW=8:
//     acc_cnt/iss_cnt wrap to 0; rst mid-stream gives all reset values next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared Mini ALU definitions: operand/opcode widths, opcode encodings and
// the request record carried from the operand source to the datapath.
package alu_pkg;

    localparam int ALU_WIDTH = 6;
    localparam int ALU_OPW   = 3;

    localparam logic [ALU_OPW-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'd2;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'd3;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;
    localparam logic [ALU_OPW-1:0] OP_CMP = 3'd5;

    typedef struct packed {
        logic [ALU_OPW-1:0]   op;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_op_fifo_mem.sv
// Operand FIFO storage: one write port and a registered head read. A write to
// the address being read is forwarded so an entry can become head one cycle
// after it is pushed.
module alu_op_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int EW    = ALU_OPW + 2 * ALU_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [EW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [EW-1:0] rd_data
);

    logic [DEPTH-1:0][EW-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // re is low when nothing will be valid next cycle, so the head holds.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (re)
            rd_data <= (we && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand staging FIFO in front of the Mini ALU. Buffers {op, A, B} requests
// and presents the head as registered operands toward the comparator.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [OPW-1:0]             s_op,
    input  logic [WIDTH-1:0]           s_a,
    input  logic [WIDTH-1:0]           s_b,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OPW-1:0]             m_op,
    output logic [WIDTH-1:0]           m_in1,
    output logic [WIDTH-1:0]           m_in2,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNTW-1:0]            acc_cnt,
    output logic [CNTW-1:0]            iss_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = OPW + 2 * WIDTH;

    logic          push, pop;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic          head_re;
    logic [EW-1:0] head;

    // Handshake depends on state only, so a pop never opens s_ready early.
    assign s_ready = (level != LW'(DEPTH));
    assign m_valid = (level != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(pop);
        level_nxt  = level + LW'(push) - LW'(pop);
        head_re    = !flush && (level_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            acc_cnt <= '0;
            iss_cnt <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr_nxt;
            level   <= level_nxt;
            acc_cnt <= acc_cnt + CNTW'(push);
            iss_cnt <= iss_cnt + CNTW'(pop);
        end
    end

    alu_op_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (push & ~flush),
        .wr_addr (wr_ptr),
        .wr_data ({s_op, s_a, s_b}),
        .re      (head_re),
        .rd_addr (rd_ptr_nxt),
        .rd_data (head)
    );

    assign {m_op, m_in1, m_in2} = head;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed checks of the operand staging FIFO against a
// queue-based reference model.
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int WIDTH = 6;
    localparam int OPW   = 3;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [OPW-1:0]   s_op = '0;
    logic [WIDTH-1:0] s_a = '0;
    logic [WIDTH-1:0] s_b = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [OPW-1:0]   m_op;
    logic [WIDTH-1:0] m_in1;
    logic [WIDTH-1:0] m_in2;
    logic [2:0]       level;
    logic [CNTW-1:0]  acc_cnt;
    logic [CNTW-1:0]  iss_cnt;

    alu_operand_stage #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_op(m_op), .m_in1(m_in1), .m_in2(m_in2),
        .level(level), .acc_cnt(acc_cnt), .iss_cnt(iss_cnt)
    );

    always #5 clk = ~clk;

    alu_req_t        q[$];
    logic [CNTW-1:0] exp_acc = '0;
    logic [CNTW-1:0] exp_iss = '0;
    int              errors = 0;
    int              checks = 0;

    // Advance one clock and apply the transaction rules to the model.
    task automatic cycle();
        bit do_push, do_pop;
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_acc = '0;
            exp_iss = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            do_push = s_valid && (q.size() < DEPTH);
            do_pop  = m_ready && (q.size() > 0);
            if (do_pop) begin
                void'(q.pop_front());
                exp_iss = exp_iss + 1'b1;
            end
            if (do_push) begin
                q.push_back('{op: s_op, a: s_a, b: s_b});
                exp_acc = exp_acc + 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input alu_req_t r, input logic mr, input logic fl);
        s_valid = v;
        s_op    = r.op;
        s_a     = r.a;
        s_b     = r.b;
        m_ready = mr;
        flush   = fl;
    endtask

    function automatic alu_req_t rnd_req();
        alu_req_t r;
        r.op = OPW'($urandom_range(0, 5));
        r.a  = WIDTH'($urandom);
        r.b  = WIDTH'($urandom);
        return r;
    endfunction

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_ready, m_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_hs: got s_ready/m_valid=%b expected 10", {s_ready, m_valid});
        end
        checks++;
        if ({m_op, m_in1, m_in2} !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {m_op, m_in1, m_in2});
        end
        checks++;
        if (level !== 3'd0 || acc_cnt !== 8'd0 || iss_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_cnt: got level=%0d acc=%0d iss=%0d expected 0/0/0", level, acc_cnt, iss_cnt);
        end
    endtask

    task automatic test_first_push();
        do_reset();
        drive(1'b1, '{op: OP_CMP, a: 6'h15, b: 6'h2A}, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (m_valid !== 1'b1 || m_op !== OP_CMP || m_in1 !== 6'h15 || m_in2 !== 6'h2A) begin
            errors++; $display("FAIL first_push_head: got v=%b op=%0d in1=%h in2=%h expected 1/5/15/2a", m_valid, m_op, m_in1, m_in2);
        end
        checks++;
        if (level !== 3'd1 || acc_cnt !== 8'd1) begin
            errors++; $display("FAIL first_push_cnt: got level=%0d acc=%0d expected 1/1", level, acc_cnt);
        end
        // Head must hold while stalled.
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_in1 !== 6'h15 || m_in2 !== 6'h2A) begin
            errors++; $display("FAIL first_push_hold: got v=%b in1=%h in2=%h expected 1/15/2a", m_valid, m_in1, m_in2);
        end
    endtask

    task automatic test_fill_and_full_pop();
        alu_req_t first;
        do_reset();
        first = rnd_req();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 0) ? first : rnd_req(), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd4 || s_ready !== 1'b0 || acc_cnt !== 8'd4) begin
            errors++; $display("FAIL full: got level=%0d s_ready=%b acc=%0d expected 4/0/4", level, s_ready, acc_cnt);
        end
        checks++;
        if ({m_op, m_in1, m_in2} !== first) begin
            errors++; $display("FAIL full_head: got %h expected %h", {m_op, m_in1, m_in2}, first);
        end
        drive(1'b1, rnd_req(), 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd3 || iss_cnt !== 8'd1 || acc_cnt !== 8'd4 || s_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop: got level=%0d iss=%0d acc=%0d s_ready=%b expected 3/1/4/1", level, iss_cnt, acc_cnt, s_ready);
        end
        checks++;
        if ({m_op, m_in1, m_in2} !== q[0]) begin
            errors++; $display("FAIL full_pop_head: got %h expected %h", {m_op, m_in1, m_in2}, q[0]);
        end
    endtask

    task automatic test_back_to_back();
        alu_req_t nxt;
        do_reset();
        drive(1'b1, rnd_req(), 1'b0, 1'b0);
        cycle();
        nxt = rnd_req();
        drive(1'b1, nxt, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd1 || m_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_level: got level=%0d m_valid=%b expected 1/1", level, m_valid);
        end
        checks++;
        if ({m_op, m_in1, m_in2} !== nxt) begin
            errors++; $display("FAIL b2b_head: got %h expected %h", {m_op, m_in1, m_in2}, nxt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_req(), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, rnd_req(), 1'b1, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got level=%0d m_valid=%b s_ready=%b expected 0/0/1", level, m_valid, s_ready);
        end
        checks++;
        if (acc_cnt !== 8'd3 || iss_cnt !== 8'd0) begin
            errors++; $display("FAIL flush_cnt: got acc=%0d iss=%0d expected 3/0", acc_cnt, iss_cnt);
        end
    endtask

    task automatic test_wrap_and_rst();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, rnd_req(), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle();
        checks++;
        if (acc_cnt !== 8'd0 || iss_cnt !== 8'd0 || level !== 3'd0) begin
            errors++; $display("FAIL wrap: got acc=%0d iss=%0d level=%0d expected 0/0/0", acc_cnt, iss_cnt, level);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_req(), 1'b0, 1'b0);
            cycle();
        end
        rst = 1'b1;
        drive(1'b1, rnd_req(), 1'b1, 1'b0);
        cycle();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b1 || acc_cnt !== 8'd0 || iss_cnt !== 8'd0 || {m_op, m_in1, m_in2} !== '0) begin
            errors++; $display("FAIL mid_rst: got level=%0d v=%b rdy=%b acc=%0d iss=%0d data=%h expected all reset values",
                               level, m_valid, s_ready, acc_cnt, iss_cnt, {m_op, m_in1, m_in2});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd_req(), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
            cycle();
            checks++;
            if (level !== 3'(q.size()) || s_ready !== (q.size() < DEPTH) || m_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rand_state[%0d]: got level=%0d rdy=%b v=%b expected level=%0d", i, level, s_ready, m_valid, q.size());
            end
            checks++;
            if (acc_cnt !== exp_acc || iss_cnt !== exp_iss) begin
                errors++; $display("FAIL rand_cnt[%0d]: got acc=%0d iss=%0d expected %0d/%0d", i, acc_cnt, iss_cnt, exp_acc, exp_iss);
            end
            if (q.size() > 0) begin
                checks++;
                if ({m_op, m_in1, m_in2} !== q[0]) begin
                    errors++; $display("FAIL rand_head[%0d]: got %h expected %h", i, {m_op, m_in1, m_in2}, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_and_full_pop();
        test_back_to_back();
        test_flush();
        test_wrap_and_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
